// File: rtl/ip_sequencer.sv
// Boot and fetch sequencer for the InstructionProcessor: loads ip/sp, then
// feeds one fetched word per FETCH/WAIT/ISSUE loop and pins ip while stalled.
module ip_sequencer #(
   parameter int                 WIDTH       = 16,
   parameter int                 REGS_CODING = 8,
   parameter logic [WIDTH-1:0]   NOP         = 16'b1_0000_1011_00_00_00,
   parameter int                 TIMEOUT     = 15
) (
   input  logic                   clock,
   input  logic                   nReset,
   input  logic                   start,
   input  logic                   halt,
   input  logic [WIDTH-1:0]       bootIP,
   input  logic [WIDTH-1:0]       bootSP,
   input  logic [WIDTH-1:0]       ROMAddress,
   output logic [REGS_CODING-1:0] regChoose,
   output logic [WIDTH-1:0]       regData,
   output logic [WIDTH-1:0]       ROMData,
   output logic                   memReq,
   output logic [WIDTH-1:0]       memAddr,
   input  logic                   memValid,
   input  logic [WIDTH-1:0]       memData,
   output logic                   running,
   output logic                   fault,
   output logic [WIDTH-1:0]       instrCount
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]       WAIT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [REGS_CODING-1:0] SEL_IP    = REGS_CODING'(8'b1000_0000);
   localparam logic [REGS_CODING-1:0] SEL_SP    = REGS_CODING'(8'b0100_0000);
   localparam logic [REGS_CODING-1:0] SEL_NONE  = {REGS_CODING{1'b0}};
   localparam logic [WIDTH-1:0]       ZERO_W    = {WIDTH{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_IP = 3'd1,
      S_LOAD_SP = 3'd2,
      S_FETCH   = 3'd3,
      S_WAIT    = 3'd4,
      S_ISSUE   = 3'd5,
      S_HALTED  = 3'd6,
      S_FAULT   = 3'd7
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   held_addr_q, held_addr_d;
   logic [WIDTH-1:0]   instr_q, instr_d;
   logic [WIDTH-1:0]   boot_ip_q, boot_ip_d;
   logic [WIDTH-1:0]   boot_sp_q, boot_sp_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [WIDTH-1:0]   instr_count_q, instr_count_d;

   // State and datapath registers.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q       <= S_IDLE;
         held_addr_q   <= ZERO_W;
         instr_q       <= ZERO_W;
         boot_ip_q     <= ZERO_W;
         boot_sp_q     <= ZERO_W;
         wait_cnt_q    <= {CNT_W{1'b0}};
         instr_count_q <= ZERO_W;
      end else begin
         state_q       <= state_d;
         held_addr_q   <= held_addr_d;
         instr_q       <= instr_d;
         boot_ip_q     <= boot_ip_d;
         boot_sp_q     <= boot_sp_d;
         wait_cnt_q    <= wait_cnt_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Next-state and register update logic.
   always_comb begin
      state_d       = state_q;
      held_addr_d   = held_addr_q;
      instr_d       = instr_q;
      boot_ip_d     = boot_ip_q;
      boot_sp_d     = boot_sp_q;
      wait_cnt_d    = wait_cnt_q;
      instr_count_d = instr_count_q;
      case (state_q)
         S_IDLE, S_FAULT: begin
            if (start) begin
               boot_ip_d = bootIP;
               boot_sp_d = bootSP;
               state_d   = S_LOAD_IP;
            end else begin
               state_d   = state_q;
            end
         end
         S_LOAD_IP: state_d = S_LOAD_SP;
         S_LOAD_SP: state_d = S_FETCH;
         S_FETCH: begin
            held_addr_d = ROMAddress;
            wait_cnt_d  = {CNT_W{1'b0}};
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            // A response in the last allowed cycle still beats the timeout.
            if (memValid) begin
               instr_d = memData;
               state_d = S_ISSUE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_ISSUE: begin
            instr_count_d = instr_count_q + {{(WIDTH-1){1'b0}}, 1'b1};
            if (halt) begin
               state_d = S_HALTED;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_HALTED: begin
            if (!halt) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_HALTED;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from state and held registers.
   always_comb begin
      regChoose = SEL_NONE;
      regData   = ZERO_W;
      ROMData   = NOP;
      memReq    = 1'b0;
      memAddr   = held_addr_q;
      running   = 1'b0;
      fault     = 1'b0;
      case (state_q)
         S_LOAD_IP: begin
            regChoose = SEL_IP;
            regData   = boot_ip_q;
         end
         S_LOAD_SP: begin
            regChoose = SEL_SP;
            regData   = boot_sp_q;
         end
         S_FETCH: begin
            regChoose = SEL_IP;
            regData   = ROMAddress;
            running   = 1'b1;
         end
         S_WAIT: begin
            // Re-pin ip every stalled cycle so the processor cannot advance.
            memReq    = 1'b1;
            regChoose = SEL_IP;
            regData   = held_addr_q;
            running   = 1'b1;
         end
         S_ISSUE: begin
            ROMData   = instr_q;
            running   = 1'b1;
         end
         S_FAULT:  fault = 1'b1;
         default: begin
            regChoose = SEL_NONE;
         end
      endcase
   end

   assign instrCount = instr_count_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Scoreboard bench for ip_sequencer: a memory responder pushes expected issues,
// an independent monitor pops them whenever the DUT presents an ISSUE cycle.
module tb_ip_sequencer;

   localparam logic [15:0] NOP_W = 16'h42C0;

   logic        clock = 1'b0;
   logic        nReset, start, halt, memValid;
   logic [15:0] bootIP, bootSP, ROMAddress, memData;
   logic [7:0]  regChoose;
   logic [15:0] regData, ROMData, memAddr, instrCount;
   logic        memReq, running, fault;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] model_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   ip_sequencer dut (
      .clock(clock), .nReset(nReset), .start(start), .halt(halt),
      .bootIP(bootIP), .bootSP(bootSP), .ROMAddress(ROMAddress),
      .regChoose(regChoose), .regData(regData), .ROMData(ROMData),
      .memReq(memReq), .memAddr(memAddr), .memValid(memValid), .memData(memData),
      .running(running), .fault(fault), .instrCount(instrCount)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every ISSUE cycle must match the oldest expected word; otherwise NOP.
   initial begin
      logic        pend;
      logic [15:0] pend_cnt;
      exp_t        e;
      pend = 1'b0;
      pend_cnt = 16'h0000;
      forever begin
         @(negedge clock);
         if (pend) begin
            chk("count", 32'(instrCount), 32'(pend_cnt));
            pend = 1'b0;
         end
         if (nReset && running && !memReq && regChoose == 8'h00) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 32'(ROMData), 32'(NOP_W));
            end else begin
               e = exp_q.pop_front();
               chk("issue_word", 32'(ROMData), 32'(e.instr));
               pend_cnt = e.cnt;
               pend = 1'b1;
            end
         end else begin
            chk("nop", 32'(ROMData), 32'(NOP_W));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Start pulse from IDLE/FAULT; returns at the negedge of the FETCH cycle.
   task automatic boot(input logic [15:0] ip, input logic [15:0] sp);
      bootIP = ip; bootSP = sp; start = 1'b1;
      @(negedge clock);
      start = 1'b0; bootIP = 16'($urandom); bootSP = 16'($urandom);
      chk("load_ip_sel", 32'(regChoose), 32'h80);
      chk("load_ip_data", 32'(regData), 32'(ip));
      chk("load_ip_fault", 32'(fault), 32'd0);
      chk("load_ip_run", 32'(running), 32'd0);
      @(negedge clock);
      chk("load_sp_sel", 32'(regChoose), 32'h40);
      chk("load_sp_data", 32'(regData), 32'(sp));
      chk("load_sp_req", 32'(memReq), 32'd0);
      @(negedge clock);
   endtask

   // Called in FETCH; serves one fetch after lat stall cycles; returns after ISSUE.
   task automatic fetch_one(input int lat, input logic [15:0] addr,
                            input logic [15:0] data, input logic hlt);
      exp_t e;
      ROMAddress = addr;
      memValid = 1'($urandom_range(0, 1));
      memData = 16'($urandom);
      #1;
      chk("fetch_sel", 32'(regChoose), 32'h80);
      chk("fetch_ip", 32'(regData), 32'(addr));
      chk("fetch_req", 32'(memReq), 32'd0);
      chk("fetch_run", 32'(running), 32'd1);
      @(negedge clock);
      ROMAddress = 16'($urandom);
      for (int i = 0; i <= lat; i++) begin
         chk("wait_req", 32'(memReq), 32'd1);
         chk("wait_addr", 32'(memAddr), 32'(addr));
         chk("wait_sel", 32'(regChoose), 32'h80);
         chk("wait_ip", 32'(regData), 32'(addr));
         if (i == lat) begin
            memValid = 1'b1; memData = data; halt = hlt;
            model_cnt = model_cnt + 16'd1;
            e.instr = data; e.cnt = model_cnt;
            exp_q.push_back(e);
         end else begin
            memValid = 1'b0; memData = 16'($urandom);
         end
         @(negedge clock);
      end
      memValid = 1'b0;
      #1 chk("issue_req", 32'(memReq), 32'd0);
      @(negedge clock);
   endtask

   // Called at the first HALTED negedge; start/memValid must be ignored.
   task automatic check_halted(input int n, input logic preload);
      for (int i = 0; i < n; i++) begin
         start = (i == 0);
         memValid = 1'b1; memData = 16'($urandom);
         #1;
         chk("halt_req", 32'(memReq), 32'd0);
         chk("halt_run", 32'(running), 32'd0);
         chk("halt_sel", 32'(regChoose), 32'h00);
         chk("halt_fault", 32'(fault), 32'd0);
         if (preload && i == 0) force dut.instr_count_q = 16'hFFFE;
         @(negedge clock);
      end
      if (preload) begin
         release dut.instr_count_q;
         model_cnt = 16'hFFFE;
      end
      start = 1'b0; memValid = 1'b0; halt = 1'b0;
      @(negedge clock);
   endtask

   task automatic timeout_fetch(input logic [15:0] addr);
      ROMAddress = addr; memValid = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 15; i++) begin
         chk("to_req", 32'(memReq), 32'd1);
         @(negedge clock);
      end
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_req_off", 32'(memReq), 32'd0);
      chk("to_run", 32'(running), 32'd0);
   endtask

   initial begin
      int          lat;
      logic        hlt;
      nReset = 1'b0; start = 1'b0; halt = 1'b0; memValid = 1'b0;
      bootIP = 16'h0000; bootSP = 16'h0000; ROMAddress = 16'h1234; memData = 16'h0000;
      model_cnt = 16'h0000;
      #1;
      chk("rst_sel", 32'(regChoose), 32'h00);
      chk("rst_data", 32'(regData), 32'h0);
      chk("rst_rom", 32'(ROMData), 32'(NOP_W));
      chk("rst_req", 32'(memReq), 32'd0);
      chk("rst_addr", 32'(memAddr), 32'h0);
      chk("rst_run", 32'(running), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_count", 32'(instrCount), 32'h0);
      @(negedge clock); @(negedge clock);
      nReset = 1'b1;
      @(negedge clock);
      chk("idle_run", 32'(running), 32'd0);

      boot(16'h0010, 16'hFFFF);
      fetch_one(0, 16'h0010, 16'b11_0000_1010_00_00_01, 1'b0);
      fetch_one(0, 16'h0011, 16'($urandom), 1'b0);
      fetch_one(5, 16'h0012, 16'($urandom), 1'b0);
      fetch_one(14, 16'h0013, 16'($urandom), 1'b0);
      timeout_fetch(16'h0014);

      @(negedge clock);
      chk("fault_hold", 32'(fault), 32'd1);
      boot(16'h0100, 16'h8000);

      for (int k = 0; k < 30; k++) begin
         lat = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 14) : $urandom_range(0, 3);
         hlt = ($urandom_range(0, 5) == 0);
         fetch_one(lat, 16'($urandom), 16'($urandom), hlt);
         if (hlt) check_halted($urandom_range(2, 4), 1'b0);
      end

      fetch_one(1, 16'($urandom), 16'($urandom), 1'b1);
      check_halted(3, 1'b1);
      fetch_one(2, 16'($urandom), 16'($urandom), 1'b1);
      check_halted(2, 1'b0);
      fetch_one(0, 16'($urandom), 16'($urandom), 1'b0);

      ROMAddress = 16'hBEEF;
      @(negedge clock);
      chk("pre_rst_req", 32'(memReq), 32'd1);
      #2 nReset = 1'b0;
      #1;
      chk("arst_req", 32'(memReq), 32'd0);
      chk("arst_rom", 32'(ROMData), 32'(NOP_W));
      chk("arst_run", 32'(running), 32'd0);
      chk("arst_addr", 32'(memAddr), 32'h0);
      chk("arst_count", 32'(instrCount), 32'h0);
      model_cnt = 16'h0000;
      @(negedge clock);
      nReset = 1'b1; memValid = 1'b1; memData = 16'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("late_valid_run", 32'(running), 32'd0);
         chk("late_valid_req", 32'(memReq), 32'd0);
      end
      memValid = 1'b0;
      boot(16'h0200, 16'h0300);
      fetch_one(0, 16'h0200, 16'($urandom), 1'b0);
      repeat (2) @(negedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
